// File: rtl/dmem_arb_pkg.sv
// Shared types and default tuning constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    S_CORE,
    S_HOST,
    S_COOL
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_HOST
  } owner_t;

  localparam int MAX_WAIT_DEF  = 4;
  localparam int BURST_MAX_DEF = 16;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module arb_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for the single-port data memory.
// Optional statistics counters enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_WAIT  = MAX_WAIT_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_wr,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_wr,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stat_host_beats,
  output logic [15:0]   stat_core_stalls
);

  arb_state_t    state_q, state_d;
  owner_t        owner;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d;
  logic          host_rvalid_q, host_rvalid_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;

  always_comb begin
    owner      = OWN_NONE;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_cnt_d = beat_cnt_q;
    if (reset) begin
      unique case (state_q)
        S_CORE: begin
          if (host_req && (!core_req || (wait_cnt_q >= 4'(MAX_WAIT)))) begin
            owner      = OWN_HOST;
            beat_cnt_d = 8'd1;
            if (core_req) wait_cnt_d = '0;
            // A cap of one beat means the entry beat already exhausts the burst.
            state_d    = (BURST_MAX == 1) ? S_COOL : S_HOST;
          end else if (core_req) begin
            owner      = OWN_CORE;
            wait_cnt_d = host_req ? wait_cnt_q + 4'd1 : 4'd0;
          end
        end
        S_HOST: begin
          if (host_req) begin
            owner      = OWN_HOST;
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (beat_cnt_q == 8'(BURST_MAX - 1)) state_d = S_COOL;
          end else begin
            owner      = core_req ? OWN_CORE : OWN_NONE;
            beat_cnt_d = '0;
            state_d    = S_CORE;
          end
        end
        S_COOL: begin
          owner      = core_req ? OWN_CORE : OWN_NONE;
          wait_cnt_d = '0;
          beat_cnt_d = '0;
          state_d    = S_CORE;
        end
        default: state_d = S_CORE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    mem_wr_en = 1'b0;
    if (owner == OWN_HOST) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_wr_en = host_wr;
    end else if (owner == OWN_CORE) begin
      mem_wr_en = core_wr;
    end
  end

  assign core_rdata = mem_rdata;
  assign host_gnt   = (owner == OWN_HOST);
  assign core_stall = reset && core_req && (owner != OWN_CORE);

  always_comb begin
    host_rvalid_d = host_gnt && !host_wr;
    host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_CORE;
      wait_cnt_q    <= '0;
      beat_cnt_q    <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  arb_sat_counter #(.W(16)) u_host_beats (
    .clk   (clk),
    .reset (reset),
    .inc   (host_gnt),
    .count (stat_host_beats)
  );

  arb_sat_counter #(.W(16)) u_core_stalls (
    .clk   (clk),
    .reset (reset),
    .inc   (core_stall),
    .count (stat_core_stalls)
  );
`else
  assign stat_host_beats  = '0;
  assign stat_core_stalls = '0;
`endif

endmodule
